// File: rtl/rv_pkg.sv
// Shared widths and RV32I opcode constants for the memory/immediate front end.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator; B and J results are the byte offset halved,
// the branch adder's shift restores bit 0.
module rv_imm_gen
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] imm_out
);

  logic [6:0] opcode;
  logic       s;

  assign opcode = instr[6:0];
  assign s      = instr[31];

  always_comb begin
    imm_out = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR:
        imm_out = {{20{s}}, instr[31:20]};
      OP_STORE:
        imm_out = {{20{s}}, instr[31:25], instr[11:7]};
      OP_BRANCH:
        imm_out = {{20{s}}, s, instr[7], instr[30:25], instr[11:8]};
      OP_JAL:
        imm_out = {{12{s}}, s, instr[19:12], instr[20], instr[30:21]};
      OP_LUI, OP_AUIPC:
        imm_out = {instr[31:12], 12'b0};
      default:
        imm_out = '0;
    endcase
  end

endmodule

// File: rtl/rv_mem_imm_unit.sv
// Instruction memory, data memory and immediate generator of the single-cycle core.
// Both memories read combinationally, write on clk, and clear asynchronously on rst.
module rv_mem_imm_unit #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int DEPTH = rv_pkg::DEPTH,
  parameter int AW    = rv_pkg::AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr,
  input  logic            imem_we,
  input  logic [AW-1:0]   imem_waddr,
  input  logic [XLEN-1:0] imem_wdata,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  output logic [XLEN-1:0] dmem_rdata,
  output logic [XLEN-1:0] imm_out
);

  logic [XLEN-1:0] imem [DEPTH];
  logic [XLEN-1:0] dmem [DEPTH];
  logic [AW-1:0]   pc_word;
  logic [AW-1:0]   dmem_word;
  logic            unused_addr_bits;

  // Word index only: low bits dropped (no misalignment), high bits dropped (wrap).
  assign pc_word   = pc[AW+1:2];
  assign dmem_word = dmem_addr[AW+1:2];
  assign unused_addr_bits = ^{pc[XLEN-1:AW+2], pc[1:0],
                              dmem_addr[XLEN-1:AW+2], dmem_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) imem[i] <= '0;
    end else if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) dmem[i] <= '0;
    end else if (mem_write) begin
      dmem[dmem_word] <= dmem_wdata;
    end
  end

  assign instr      = imem[pc_word];
  assign dmem_rdata = mem_read ? dmem[dmem_word] : '0;

  rv_imm_gen u_imm_gen (
    .instr   (instr),
    .imm_out (imm_out)
  );

endmodule

// File: tb/tb_rv_mem_imm_unit.sv
// Bench for rv_mem_imm_unit: directed vectors, corner sequences and random traffic
// against an array-based model of both memories and the immediate encodings.
module tb_rv_mem_imm_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        imem_we;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic [31:0] imm_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_imem [64];
  logic [31:0] ref_dmem [64];

  always #5 clk = ~clk;

  rv_mem_imm_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .instr      (instr),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .imm_out    (imm_out)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] imm;
  } imm_vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Immediate from the architectural byte offsets (B/J reported halved).
  function automatic logic [31:0] ref_imm(input logic [31:0] w);
    int off;
    logic signed [31:0] sw;
    sw = w;
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: return sw >>> 20;
      7'b0100011: begin
        off = int'(sw >>> 25) * 32 + int'(w[11:7]);
        return off;
      end
      7'b1100011: begin
        off = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        return off / 2;
      end
      7'b1101111: begin
        off = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        return off / 2;
      end
      7'b0110111, 7'b0010111: return w & 32'hFFFF_F000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 64; i++) begin
      ref_imem[i] = '0;
      ref_dmem[i] = '0;
    end
  endtask

  task automatic load_imem(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    @(posedge clk);
    ref_imem[a] = d;
    #1 imem_we = 1'b0;
  endtask

  task automatic store_dmem(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write = 1'b1; dmem_addr = a; dmem_wdata = d;
    @(posedge clk);
    ref_dmem[a[7:2]] = d;
    #1 mem_write = 1'b0;
  endtask

  imm_vec_t vecs [7];
  logic [6:0] ops [9];

  initial begin
    vecs[0] = '{"addi5",   32'h0050_0093, 32'h0000_0005};
    vecs[1] = '{"addi_m1", 32'hFFF0_0093, 32'hFFFF_FFFF};
    vecs[2] = '{"sw8",     32'h0011_2423, 32'h0000_0008};
    vecs[3] = '{"beq_m4",  32'hFE00_0EE3, 32'hFFFF_FFFE};
    vecs[4] = '{"lui",     32'h1234_52B7, 32'h1234_5000};
    vecs[5] = '{"jal8",    32'h0080_006F, 32'h0000_0004};
    vecs[6] = '{"rtype",   32'h0000_0033, 32'h0000_0000};
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33};

    rst = 1'b1; pc = '0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    mem_read = 1'b1; mem_write = 1'b0; dmem_addr = 32'h0C; dmem_wdata = '0;
    clear_model();
    #12;
    check("rst_instr", instr, 32'h0);
    check("rst_rdata", dmem_rdata, 32'h0);
    check("rst_imm",   imm_out, 32'h0);
    @(negedge clk) rst = 1'b0;

    // Asynchronous clear seen without any clock edge.
    store_dmem(32'h0C, 32'hDEAD_BEEF);
    @(negedge clk);
    mem_read = 1'b1; dmem_addr = 32'h0C;
    #1 check("pre_rst_rd", dmem_rdata, 32'hDEAD_BEEF);
    #1 rst = 1'b1;
    #1 check("async_rst_rd", dmem_rdata, 32'h0);
    rst = 1'b0;
    clear_model();

    store_dmem(32'h10, 32'h1234_5678);
    @(negedge clk);
    mem_read = 1'b1; dmem_addr = 32'h10;
    #1 check("rd_0x10", dmem_rdata, 32'h1234_5678);
    dmem_addr = 32'h13;
    #1 check("rd_0x13", dmem_rdata, 32'h1234_5678);
    dmem_addr = 32'h110;
    #1 check("rd_0x110", dmem_rdata, 32'h1234_5678);
    mem_read = 1'b0;
    #1 check("rd_disabled", dmem_rdata, 32'h0);

    for (int i = 0; i < 7; i++) begin
      load_imem(6'(i + 1), vecs[i].instr);
      @(negedge clk);
      pc = 32'(i + 1) * 4;
      #1;
      check({vecs[i].name, "_instr"}, instr, vecs[i].instr);
      check({vecs[i].name, "_imm"}, imm_out, vecs[i].imm);
      check({vecs[i].name, "_model"}, imm_out, ref_imm(vecs[i].instr));
    end

    // Load into the word pc points at: visible only after the edge.
    @(negedge clk);
    pc = 32'h4; imem_we = 1'b1; imem_waddr = 6'd1; imem_wdata = 32'h1234_52B7;
    #1 check("imem_pre_edge", instr, 32'h0050_0093);
    @(posedge clk);
    ref_imem[1] = 32'h1234_52B7;
    #1 imem_we = 1'b0;
    check("imem_post_edge", instr, 32'h1234_52B7);

    store_dmem(32'h20, 32'hA);
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b1; dmem_addr = 32'h20; dmem_wdata = 32'hB;
    #1 check("rw_before", dmem_rdata, 32'hA);
    @(posedge clk);
    ref_dmem[8] = 32'hB;
    #1 check("rw_after", dmem_rdata, 32'hB);
    mem_write = 1'b0;

    // Reset wins over a write on the same edge.
    @(negedge clk);
    mem_write = 1'b1; dmem_addr = 32'h24; dmem_wdata = 32'h55; rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0; mem_write = 1'b0; mem_read = 1'b1;
    clear_model();
    #1 check("rst_vs_write", dmem_rdata, 32'h0);
    check("rst_clr_imem", instr, 32'h0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] w;
      @(negedge clk);
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 8)];
      imem_we    = ($urandom_range(0, 1) == 1);
      imem_waddr = 6'($urandom);
      imem_wdata = w;
      mem_write  = ($urandom_range(0, 2) == 0);
      mem_read   = ($urandom_range(0, 3) != 0);
      dmem_addr  = $urandom;
      dmem_wdata = $urandom;
      pc         = $urandom;
      #1;
      check("rnd_instr", instr, ref_imem[pc[7:2]]);
      check("rnd_imm",   imm_out, ref_imm(ref_imem[pc[7:2]]));
      check("rnd_rdata", dmem_rdata, mem_read ? ref_dmem[dmem_addr[7:2]] : 32'h0);
      @(posedge clk);
      if (imem_we)   ref_imem[imem_waddr] = imem_wdata;
      if (mem_write) ref_dmem[dmem_addr[7:2]] = dmem_wdata;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
